// File: rtl/gpio_reg_pkg.sv
// Shared types and constants for the GPIO register-file arbiter.
// Build option GPIO_ARB_RR_EN selects round-robin arbitration.
package gpio_reg_pkg;

    localparam int GPIO_AW = 3;
    localparam int GPIO_DW = 32;

    localparam logic [GPIO_AW-1:0] GPIO_REG_DATA_IN    = 3'b000;
    localparam logic [GPIO_AW-1:0] GPIO_REG_DATA_OUT   = 3'b001;
    localparam logic [GPIO_AW-1:0] GPIO_REG_DIR        = 3'b010;
    localparam logic [GPIO_AW-1:0] GPIO_REG_IRQ_EN     = 3'b011;
    localparam logic [GPIO_AW-1:0] GPIO_REG_IRQ_TYPE   = 3'b100;
    localparam logic [GPIO_AW-1:0] GPIO_REG_IRQ_POL    = 3'b101;
    localparam logic [GPIO_AW-1:0] GPIO_REG_IRQ_STATUS = 3'b110;
    localparam logic [GPIO_AW-1:0] GPIO_REG_IRQ_CLEAR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/gpio_arb_pick.sv
// Combinational grant select between the two requesters.
// GPIO_ARB_RR_EN defined: round-robin on contention; otherwise port 0 always wins.
module gpio_arb_pick
    import gpio_reg_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic any_valid,
    output logic grant
);

    assign any_valid = valid0 | valid1;

`ifdef GPIO_ARB_RR_EN
    // On contention the port that was not served last goes first.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = other_port(last_grant);
        end else if (valid1) begin
            grant = 1'b1;
        end
    end
`else
    logic unused_last_grant;

    assign unused_last_grant = last_grant;
    assign grant             = ~valid0 & valid1;
`endif

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Shares the GPIO register-file port between CPU (port 0) and debug/DMA (port 1).
// Build option GPIO_ARB_RR_EN switches arbitration from fixed priority to round-robin.
module gpio_reg_arbiter
    import gpio_reg_pkg::*;
#(
    parameter int DW = GPIO_DW,
    parameter int AW = GPIO_AW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0_valid,
    input  logic          req0_r_wn,
    input  logic [AW-1:0] req0_addr,
    input  logic [3:0]    req0_wben,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_valid,
    input  logic          req1_r_wn,
    input  logic [AW-1:0] req1_addr,
    input  logic [3:0]    req1_wben,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,

    output logic [AW-1:0] reg_addr,
    output logic [3:0]    reg_wben,
    output logic          reg_r_wn,
    output logic [DW-1:0] reg_wdata,
    input  logic [DW-1:0] reg_rdata,

    output logic          busy,
    output logic          grant_id
);

    arb_state_e    state_q, state_d;
    logic          grant_id_q, grant_id_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [3:0]    reg_wben_q, reg_wben_d;
    logic          reg_r_wn_q, reg_r_wn_d;
    logic [DW-1:0] reg_wdata_q, reg_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          any_valid;
    logic          pick;
    logic          accept;
    logic          sel_r_wn;
    logic [AW-1:0] sel_addr;
    logic [3:0]    sel_wben;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] resp_data;

    gpio_arb_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .any_valid  (any_valid),
        .grant      (pick)
    );

    always_comb begin
        sel_r_wn  = req0_r_wn;
        sel_addr  = req0_addr;
        sel_wben  = req0_wben;
        sel_wdata = req0_wdata;
        if (pick) begin
            sel_r_wn  = req1_r_wn;
            sel_addr  = req1_addr;
            sel_wben  = req1_wben;
            sel_wdata = req1_wdata;
        end
    end

    // Ready is held low while reset is asserted so no handshake completes into a flop in reset.
    assign accept = (state_q == IDLE) && any_valid && reset;

    // Completion data: what the register block returned for a read, zero for a write.
    assign resp_data = reg_r_wn_q ? reg_rdata : '0;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_wben_d   = 4'b0000;
        reg_r_wn_d   = 1'b1;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d     = ACCESS;
                    grant_id_d  = pick;
                    reg_addr_d  = sel_addr;
                    reg_wdata_d = sel_wdata;
                    reg_r_wn_d  = sel_r_wn;
                    reg_wben_d  = sel_r_wn ? 4'b0000 : sel_wben;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (grant_id_q) begin
                    rdata1_d = resp_data;
                end else begin
                    rdata0_d = resp_data;
                end
            end
            RESP: begin
                state_d      = IDLE;
                last_grant_d = grant_id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            reg_addr_q   <= '0;
            reg_wben_q   <= 4'b0000;
            reg_r_wn_q   <= 1'b1;
            reg_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            reg_addr_q   <= reg_addr_d;
            reg_wben_q   <= reg_wben_d;
            reg_r_wn_q   <= reg_r_wn_d;
            reg_wdata_q  <= reg_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign req0_ready  = accept & ~pick;
    assign req1_ready  = accept & pick;
    assign req0_rvalid = (state_q == RESP) && !grant_id_q;
    assign req1_rvalid = (state_q == RESP) && grant_id_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    assign reg_addr  = reg_addr_q;
    assign reg_wben  = reg_wben_q;
    assign reg_r_wn  = reg_r_wn_q;
    assign reg_wdata = reg_wdata_q;

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Self-checking bench for gpio_reg_arbiter: directed steps plus random traffic
// scored against a transaction-level model (cycle arithmetic and a register array).
module tb_gpio_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        req0_valid, req0_r_wn, req0_ready, req0_rvalid;
    logic [2:0]  req0_addr;
    logic [3:0]  req0_wben;
    logic [31:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_r_wn, req1_ready, req1_rvalid;
    logic [2:0]  req1_addr;
    logic [3:0]  req1_wben;
    logic [31:0] req1_wdata, req1_rdata;

    logic [2:0]  reg_addr;
    logic [3:0]  reg_wben;
    logic        reg_r_wn;
    logic [31:0] reg_wdata, reg_rdata;
    logic        busy, grant_id;

    int nChecks;
    int nFail;

    // Model state: cycle count, cycle of the last grant, and the granted transaction.
    int          cyc;
    int          grantCyc;
    int          grantedNow;
    logic        curPort, curRw;
    logic [2:0]  curAddr;
    logic [3:0]  curWben;
    logic [31:0] curWdata, curData;
    logic        mLast, mGid;
    logic [31:0] mRdata [2];
    logic [31:0] refMem [8];
    logic [31:0] fakeMem [8];
    logic        obsRdy0, obsRdy1;

    gpio_reg_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_r_wn   (req0_r_wn),
        .req0_addr   (req0_addr),
        .req0_wben   (req0_wben),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_r_wn   (req1_r_wn),
        .req1_addr   (req1_addr),
        .req1_wben   (req1_wben),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .reg_addr    (reg_addr),
        .reg_wben    (reg_wben),
        .reg_r_wn    (reg_r_wn),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    // Stand-in register block: combinational read, byte-enabled write on the clock edge.
    assign reg_rdata = fakeMem[reg_addr];

    always @(posedge clk) begin
        if (!reg_r_wn) begin
            for (int b = 0; b < 4; b++) begin
                if (reg_wben[b]) begin
                    fakeMem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic pickModel(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef GPIO_ARB_RR_EN
            return !mLast;
`else
            return 1'b0;
`endif
        end
        return v1;
    endfunction

    task automatic resetModel();
        grantCyc  = -10;
        mLast     = 1'b1;
        mGid      = 1'b0;
        mRdata[0] = '0;
        mRdata[1] = '0;
    endtask

    // One clock cycle: drive requests, predict this cycle, check at the falling edge.
    task automatic applyStimulus(
        input logic v0, input logic rw0, input logic [2:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
        input logic v1, input logic rw1, input logic [2:0] a1, input logic [3:0] be1, input logic [31:0] wd1);
        logic expRdy0, expRdy1, inAcc, inResp, p;
        req0_valid = v0; req0_r_wn = rw0; req0_addr = a0; req0_wben = be0; req0_wdata = wd0;
        req1_valid = v1; req1_r_wn = rw1; req1_addr = a1; req1_wben = be1; req1_wdata = wd1;
        expRdy0    = 1'b0;
        expRdy1    = 1'b0;
        grantedNow = -1;
        if (cyc == grantCyc + 1) mGid = curPort;
        if (cyc >= grantCyc + 3 && (v0 || v1)) begin
            p          = pickModel(v0, v1);
            grantCyc   = cyc;
            grantedNow = p ? 1 : 0;
            curPort    = p;
            curRw      = p ? rw1 : rw0;
            curAddr    = p ? a1 : a0;
            curWben    = p ? be1 : be0;
            curWdata   = p ? wd1 : wd0;
            mLast      = p;
            if (p) expRdy1 = 1'b1;
            else   expRdy0 = 1'b1;
        end
        inAcc  = (cyc == grantCyc + 1);
        inResp = (cyc == grantCyc + 2);
        if (inAcc) begin
            if (curRw) begin
                curData = refMem[curAddr];
            end else begin
                curData = '0;
                for (int b = 0; b < 4; b++) begin
                    if (curWben[b]) refMem[curAddr][8*b +: 8] = curWdata[8*b +: 8];
                end
            end
        end
        if (inResp) mRdata[curPort] = curData;

        @(negedge clk);
        obsRdy0 = req0_ready;
        obsRdy1 = req1_ready;
        checkOutput($sformatf("c%0d ready0", cyc), 32'(req0_ready), 32'(expRdy0));
        checkOutput($sformatf("c%0d ready1", cyc), 32'(req1_ready), 32'(expRdy1));
        checkOutput($sformatf("c%0d rvalid0", cyc), 32'(req0_rvalid), 32'(inResp && !curPort));
        checkOutput($sformatf("c%0d rvalid1", cyc), 32'(req1_rvalid), 32'(inResp && curPort));
        checkOutput($sformatf("c%0d rdata0", cyc), req0_rdata, mRdata[0]);
        checkOutput($sformatf("c%0d rdata1", cyc), req1_rdata, mRdata[1]);
        checkOutput($sformatf("c%0d busy", cyc), 32'(busy), 32'(inAcc || inResp));
        checkOutput($sformatf("c%0d grant_id", cyc), 32'(grant_id), 32'(mGid));
        checkOutput($sformatf("c%0d reg_r_wn", cyc), 32'(reg_r_wn), 32'(inAcc ? curRw : 1'b1));
        checkOutput($sformatf("c%0d reg_wben", cyc), 32'(reg_wben), 32'((inAcc && !curRw) ? curWben : 4'b0000));
        if (inAcc) checkOutput($sformatf("c%0d reg_addr", cyc), 32'(reg_addr), 32'(curAddr));
        if (inAcc && !curRw) checkOutput($sformatf("c%0d reg_wdata", cyc), reg_wdata, curWdata);

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b1, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 3'd0, 4'd0, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " reg_r_wn"}, 32'(reg_r_wn), 32'd1);
        checkOutput({tag, " reg_wben"}, 32'(reg_wben), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " ready0"}, 32'(req0_ready), 32'd0);
        checkOutput({tag, " ready1"}, 32'(req1_ready), 32'd0);
        checkOutput({tag, " rvalid0"}, 32'(req0_rvalid), 32'd0);
        checkOutput({tag, " rvalid1"}, 32'(req1_rvalid), 32'd0);
    endtask

    // Reset held low for 10 ns with a request pending, then released away from a clock edge.
    task automatic doReset();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkResetState("rst");
        checkOutput("rst reg_addr", 32'(reg_addr), 32'd0);
        checkOutput("rst reg_wdata", reg_wdata, 32'd0);
        checkOutput("rst rdata0", req0_rdata, 32'd0);
        checkOutput("rst rdata1", req1_rdata, 32'd0);
        checkOutput("rst grant_id", 32'(grant_id), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #9;
        reset = 1'b1;
        #1;
        checkResetState("post-rst");
        @(posedge clk);
        #1;
        resetModel();
    endtask

    initial begin
        logic        pv [2];
        logic        prw [2];
        logic [2:0]  pa [2];
        logic [3:0]  pbe [2];
        logic [31:0] pwd [2];
        logic [31:0] saved;
        int          cnt0, cnt1;

        nChecks = 0;
        nFail   = 0;
        cyc     = 0;
        reset   = 1'b1;
        req0_valid = 1'b0; req0_r_wn = 1'b1; req0_addr = '0; req0_wben = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_r_wn = 1'b1; req1_addr = '0; req1_wben = '0; req1_wdata = '0;
        curPort = 1'b0; curRw = 1'b1; curAddr = '0; curWben = '0; curWdata = '0; curData = '0;
        for (int i = 0; i < 8; i++) begin
            saved      = $urandom;
            refMem[i]  = saved;
            fakeMem[i] <= saved;
        end
        refMem[6]  = 32'h0000_8001;
        fakeMem[6] <= 32'h0000_8001;
        resetModel();
        #1;

        $display("[TB] test 1: reset");
        doReset();

        $display("[TB] test 2: port 0 read of 3'b110");
        applyStimulus(1'b1, 1'b1, 3'b110, 4'h0, 32'd0, 1'b0, 1'b1, 3'd0, 4'd0, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("t2 rdata0", req0_rdata, 32'h0000_8001);

        $display("[TB] test 3: port 1 write");
        applyStimulus(1'b0, 1'b1, 3'd0, 4'd0, 32'd0, 1'b1, 1'b0, 3'b001, 4'b0011, 32'hFFFF_9249);
        idleCycle();
        idleCycle();
        checkOutput("t3 rdata1", req1_rdata, 32'd0);

        $display("[TB] test 4: simultaneous requests for 12 cycles");
        doReset();
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd2, 4'd0, 32'd0, 1'b1, 1'b1, 3'd4, 4'd0, 32'd0);
            if (obsRdy0) cnt0++;
            if (obsRdy1) cnt1++;
        end
`ifdef GPIO_ARB_RR_EN
        checkOutput("t4 grants0", 32'(cnt0), 32'd2);
        checkOutput("t4 grants1", 32'(cnt1), 32'd2);
`else
        checkOutput("t4 grants0", 32'(cnt0), 32'd4);
        checkOutput("t4 grants1", 32'(cnt1), 32'd0);
`endif
        idleCycle();

        $display("[TB] test 5: reset during write access");
        saved = refMem[2];
        applyStimulus(1'b1, 1'b0, 3'd2, 4'hF, ~saved, 1'b0, 1'b1, 3'd0, 4'd0, 32'd0);
        req0_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkResetState("t5 in-access");
        @(posedge clk);
        #1;
        checkResetState("t5 held");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        resetModel();
        idleCycle();
        applyStimulus(1'b1, 1'b1, 3'd2, 4'd0, 32'd0, 1'b0, 1'b1, 3'd0, 4'd0, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("t5 readback", req0_rdata, saved);

        $display("[TB] test 6: write with wben = 0");
        saved = refMem[5];
        applyStimulus(1'b0, 1'b1, 3'd0, 4'd0, 32'd0, 1'b1, 1'b0, 3'd5, 4'h0, ~saved);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 1'b1, 3'd0, 4'd0, 32'd0, 1'b1, 1'b1, 3'd5, 4'd0, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("t6 readback", req1_rdata, saved);

        $display("[TB] random traffic");
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prw[i] = 1'b1; pa[i] = '0; pbe[i] = '0; pwd[i] = '0;
        end
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom_range(0, 1) == 1)) begin
                    pv[p]  = 1'b1;
                    prw[p] = 1'($urandom_range(0, 1));
                    pa[p]  = 3'($urandom_range(0, 7));
                    pbe[p] = 4'($urandom_range(0, 15));
                    pwd[p] = $urandom;
                end
            end
            applyStimulus(pv[0], prw[0], pa[0], pbe[0], pwd[0], pv[1], prw[1], pa[1], pbe[1], pwd[1]);
            if (grantedNow >= 0) pv[grantedNow] = 1'b0;
        end
        idleCycle();
        idleCycle();
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
